// File: rtl/ahb_matrix_pkg.sv
// ahb_matrix_pkg: AHB encodings shared by the matrix input stages and output arbiters
package ahb_matrix_pkg;
  typedef enum logic [1:0] {TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ} htrans_e;
  typedef enum logic [2:0] {
    BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4,
    BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
  } hburst_e;
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_addr_hold_reg.sv
// ahb_addr_hold_reg: enable-loaded address-phase attribute bank with live/held select
module ahb_addr_hold_reg #(
  parameter int W = 46
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         held_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] hold_q;
  always_ff @(posedge clk_i)
    if (rst_i) hold_q <= '0;
    else if (en_i) hold_q <= d_i;
  assign q_o = held_i ? hold_q : d_i;
endmodule

// File: rtl/ahb_matrix_input_stage.sv
// ahb_matrix_input_stage: holds a master's address phase until its output port is granted
module ahb_matrix_input_stage
  import ahb_matrix_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MW         = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [MW-1:0]         HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_dec,
  output logic [ADDR_WIDTH-1:0] addr_dec,
  output logic [1:0]            trans_dec,
  output logic                  write_dec,
  output logic [2:0]            size_dec,
  output logic [2:0]            burst_dec,
  output logic [MW-1:0]         prot_dec,
  output logic                  lock_dec,
  output logic                  held_tran,
  input  logic                  active_dec,
  input  logic                  readyout_dec,
  input  logic                  resp_dec
);
  localparam int AW = ADDR_WIDTH + MW + 10;
  logic pend_q, pend_d, dp_q, dp_d, trans_valid, grant;
  logic [AW-1:0] live, pres;
  assign trans_valid = HSELS & HREADYS & HTRANSS[1];
  assign grant       = active_dec & readyout_dec;
  always_comb begin
    pend_d = pend_q ? ~grant : trans_valid & ~grant;
    dp_d   = ((trans_valid | pend_q) & grant) ? 1'b1 : readyout_dec ? 1'b0 : dp_q;
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      pend_q <= 1'b0;
      dp_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dp_q   <= dp_d;
    end
  assign live = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
  ahb_addr_hold_reg #(.W(AW)) u_hold (
    .clk_i (HCLK),
    .rst_i (HRESET),
    .en_i  (HSELS & HREADYS),
    .held_i(pend_q),
    .d_i   (live),
    .q_o   (pres)
  );
  assign {addr_dec, trans_dec, write_dec, size_dec, burst_dec, prot_dec, lock_dec} = pres;
  assign sel_dec    = pend_q | (HSELS & HTRANSS[1]);
  assign held_tran  = pend_q;
  // an open data phase wins: the master sees the slave's ready/response directly
  assign HREADYOUTS = dp_q ? readyout_dec : ~pend_q;
  assign HRESPS     = dp_q ? resp_dec : RESP_OKAY;
endmodule
